down_timer_ctrl: RTL and testbench
==================================

Name: down_timer_ctrl

Overview:
Loadable, prescaled down-count timer controller that sits directly upstream of the team's free-running down counters. It accepts a start value and a start command. It divides the clock by a prescale factor and decrements once per prescaled tick. It reports busy/done status and exports the tick strobe so that downstream counters can be enabled off it.

Parameters:
WIDTH, 4, bit width of load_val and count
PRESCALE, 10, clock cycles per decrement (legal range 1..2^16-1)
AUTO_RELOAD, 0, 1 = reload load_val after reaching zero and keep running

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
load_val  input  WIDTH  start value, sampled on accepted start (and on reload)
start  input  1  start request, sampled in IDLE only
pause  input  1  level; freezes prescaler and count while high in RUN/PAUSE
abort  input  1  single-cycle or level; returns to IDLE without done
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse when count reaches zero
tick  output  1  one-cycle strobe coincident with each decrement/reload edge

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; count=all ones (2^WIDTH-1); prescaler=0.
  - busy=0, done=0, tick=0.
  - rst overrides every other input.
- All outputs are registered. done and tick are high only for the cycle after the edge that produced them.
- Prescaler width is ceil(log2(PRESCALE)), minimum 1 bit. It counts 0..PRESCALE-1.
- States and transitions:
  - IDLE:
    - count holds its last value.
    - start=1 and abort=0: count<=load_val, prescaler<=0.
    - If load_val!=0, go to RUN and set busy=1 from the next cycle.
    - If load_val==0, stay in IDLE, count<=0 and done pulses on the next cycle.
  - RUN:
    - prescaler increments each clock.
    - When prescaler==PRESCALE-1: prescaler<=0, tick pulses, and count<=count-1.
    - count transition 1->0:
      - done pulses.
      - If AUTO_RELOAD=0: go to IDLE, busy=0 from the same edge, count holds 0.
      - If AUTO_RELOAD=1: stay in RUN. The next tick loads load_val instead of decrementing (tick still pulses). If load_val==0 at that reload, done pulses again on that tick.
    - pause=1: go to PAUSE. The prescaler and count do not advance on that edge.
  - PAUSE:
    - Prescaler and count frozen; busy=1; no tick.
    - pause=0: return to RUN. Counting resumes from the frozen prescaler value.
- Priority: rst > abort > pause > tick/decrement > start.
  - abort in any state: go to IDLE, prescaler<=0, count holds its current value, no done, no tick, busy=0 next cycle.
  - start while busy is ignored (no restart, no reload).
  - start and abort in the same IDLE cycle: abort wins and the start is discarded.
- Latency, with PRESCALE=P and load_val=N>0, start sampled at edge E:
  - count=N and busy=1 after E.
  - First tick/decrement at edge E+P.
  - count=0 and done=1 after edge E+N*P; busy=0 after the same edge when AUTO_RELOAD=0.
- PRESCALE=1: tick every clock in RUN; count decrements every cycle.
- Count never wraps below zero. Decrement arithmetic is modulo 2^WIDTH, but the 0 state is never decremented.
- Reset mid-run: identical to power-on reset. Any pending done/tick is suppressed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> count=4'hF, busy=0, done=0, tick=0, and all stay stable for 20 cycles with start=0.
- Basic run with P=10, load_val=3, start pulse at edge E:
  - count=3 after E, then 2/1/0 after E+10/E+20/E+30.
  - tick high 3 times; done high exactly one cycle after E+30; busy falls after E+30.
- Pause: P=4, load 5; hold pause for 7 cycles after the second tick -> count frozen at 3, no tick during the pause; done arrives 7 cycles later than the unpaused run.
- Abort and collisions:
  - abort mid-run at count=2 -> IDLE, count stays 2, no done, busy=0.
  - start+abort in the same cycle in IDLE -> remains IDLE.
  - start during RUN -> ignored.
- Zero load and P=1: load_val=0 with start -> done pulses once, busy never rises. Then P=1, load_val=4 -> count 4,3,2,1,0 on consecutive cycles, done after the fourth decrement.
- AUTO_RELOAD=1, P=2, load_val=2:
  - Sequence 2,1,0,2,1,0..., with done on each arrival at 0.
  - rst asserted mid-sequence -> count=4'hF and IDLE next cycle.

Source files
------------

// File: rtl/down_timer_ctrl.sv
// ---------------------------------------------------------------------------------------------
// down_timer_ctrl
//
// Loadable, prescaled down-count timer controller. A start command in IDLE loads the start
// value; the clock is then divided by PRESCALE and the count decrements once per prescaled
// tick until it reaches zero. The tick strobe is exported so downstream free-running counters
// can be enabled off it. Optional auto-reload keeps the timer running by reloading the start
// value on the tick that follows the arrival at zero.
//
// Parameters:
//   WIDTH        bit width of load_val and count
//   PRESCALE     clock cycles per decrement, legal range 1..2^16-1
//   AUTO_RELOAD  1 = reload load_val after reaching zero and keep running
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset
//   load_val  in   start value, sampled on an accepted start and on every reload
//   start     in   start request, only honoured in IDLE
//   pause     in   level; freezes prescaler and count while high in RUN/PAUSE
//   abort     in   returns to IDLE without done; count holds its value
//   count     out  current count value (registered)
//   busy      out  high in RUN and PAUSE
//   done      out  one-cycle pulse when the count reaches zero
//   tick      out  one-cycle strobe coincident with each decrement/reload edge
// ---------------------------------------------------------------------------------------------

module down_timer_ctrl #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned PRESCALE    = 10,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tick
);

   // Prescaler counts 0..PRESCALE-1; a PRESCALE of 1 still needs a 1-bit register.
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick_q, tick_d;

   logic             presc_wrap;

   assign presc_wrap = (presc_q == PrescLast);

   // ------------------------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         presc_q <= '0;
         count_q <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Next-state and output logic
   // Priority inside a state: abort > pause > tick/decrement > start.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      done_d  = 1'b0;
      tick_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (abort) begin
               // A start in the same cycle is discarded.
               presc_d = '0;
            end else if (start) begin
               count_d = load_val;
               presc_d = '0;
               if (load_val != '0) begin
                  state_d = StRun;
               end else begin
                  // Zero load finishes immediately without ever becoming busy.
                  done_d = 1'b1;
               end
            end
         end

         StRun, StPause: begin
            if (abort) begin
               state_d = StIdle;
               presc_d = '0;
            end else if (pause) begin
               state_d = StPause;
            end else begin
               // Leaving PAUSE counts on the same edge, so a pause held for k edges
               // delays everything by exactly k cycles.
               state_d = StRun;
               if (presc_wrap) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  if (count_q == '0) begin
                     // Only reachable with auto-reload: the tick after zero reloads
                     // instead of decrementing, so the count never wraps.
                     count_d = load_val;
                     done_d  = (load_val == '0);
                  end else begin
                     count_d = count_q - WIDTH'(1);
                     if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (!AUTO_RELOAD) begin
                           state_d = StIdle;
                        end
                     end
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
         end

         default: begin
            state_d = StIdle;
            presc_d = '0;
         end
      endcase

      // busy is registered from the next state so it changes on the same edge as the state.
      busy_d = (state_d != StIdle);
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_down_timer_ctrl
//
// Four timer instances with different prescale/reload settings share one reset. A behavioural
// model tracks, per instance, whether the timer is running, how many active (unpaused) RUN
// cycles have elapsed and the current count; a tick occurs whenever the active-cycle count is
// a multiple of the prescale factor. The model is compared against every instance on every
// falling edge, and directed literal checks pin the expected sequences.
//   inst 0: PRESCALE=10, no reload   inst 1: PRESCALE=4, no reload
//   inst 2: PRESCALE=1,  no reload   inst 3: PRESCALE=2, auto-reload
// ---------------------------------------------------------------------------------------------

module tb_down_timer_ctrl;

   localparam int N = 4;

   function automatic int unsigned ps_of(input int k);
      case (k)
         0:       return 10;
         1:       return 4;
         2:       return 1;
         default: return 2;
      endcase
   endfunction

   function automatic bit ar_of(input int k);
      return (k == 3);
   endfunction

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] load_val [N];
   logic       start    [N];
   logic       pause    [N];
   logic       abort    [N];
   logic [3:0] count    [N];
   logic       busy     [N];
   logic       done     [N];
   logic       tick     [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      down_timer_ctrl #(
         .WIDTH      (4),
         .PRESCALE   (ps_of(g)),
         .AUTO_RELOAD(ar_of(g))
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .load_val(load_val[g]),
         .start   (start[g]),
         .pause   (pause[g]),
         .abort   (abort[g]),
         .count   (count[g]),
         .busy    (busy[g]),
         .done    (done[g]),
         .tick    (tick[g])
      );
   end

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit en    = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   // Inputs as seen by the DUT at each rising edge.
   logic       rst_s;
   logic [3:0] ld_s [N];
   logic       st_s [N];
   logic       pa_s [N];
   logic       ab_s [N];

   always @(posedge clk) begin
      rst_s <= rst;
      for (int i = 0; i < N; i++) begin
         ld_s[i] <= load_val[i];
         st_s[i] <= start[i];
         pa_s[i] <= pause[i];
         ab_s[i] <= abort[i];
      end
   end

   // Behavioural model + per-cycle compare.
   bit m_run  [N];
   int m_act  [N];
   int m_cnt  [N];
   bit m_done [N];
   bit m_tick [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         m_run[i] = 1'b0;
         m_act[i] = 0;
         m_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
            m_tick[i] = 1'b0;
            if (rst_s === 1'b1) begin
               m_run[i] = 1'b0;
               m_cnt[i] = 15;
            end else if (!m_run[i]) begin
               if (st_s[i] === 1'b1 && ab_s[i] !== 1'b1) begin
                  m_cnt[i] = int'(ld_s[i]);
                  if (ld_s[i] == 4'd0) begin
                     m_done[i] = 1'b1;
                  end else begin
                     m_run[i] = 1'b1;
                     m_act[i] = 0;
                  end
               end
            end else if (ab_s[i] === 1'b1) begin
               m_run[i] = 1'b0;
            end else if (pa_s[i] !== 1'b1) begin
               m_act[i]++;
               if (m_act[i] % int'(ps_of(i)) == 0) begin
                  m_tick[i] = 1'b1;
                  if (m_cnt[i] == 0) begin
                     m_cnt[i]  = int'(ld_s[i]);
                     m_done[i] = (m_cnt[i] == 0);
                  end else begin
                     m_cnt[i]--;
                     if (m_cnt[i] == 0) begin
                        m_done[i] = 1'b1;
                        if (!ar_of(i)) m_run[i] = 1'b0;
                     end
                  end
               end
            end
         end
         if (en) begin
            for (int i = 0; i < N; i++) begin
               chk($sformatf("model u%0d count", i), 32'(count[i]), 32'(m_cnt[i]));
               chk($sformatf("model u%0d busy", i), 32'(busy[i]), 32'(m_run[i]));
               chk($sformatf("model u%0d done", i), 32'(done[i]), 32'(m_done[i]));
               chk($sformatf("model u%0d tick", i), 32'(tick[i]), 32'(m_tick[i]));
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start pulse; returns at the falling edge right after the accepting rising edge.
   task automatic go(input int i, input logic [3:0] v);
      load_val[i] = v;
      start[i]    = 1'b1;
      step(1);
      start[i]    = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         load_val[i] = 4'd0;
         start[i]    = 1'b0;
         pause[i]    = 1'b0;
         abort[i]    = 1'b0;
      end
      step(2);
      rst = 1'b0;
      en  = 1'b1;
      chk("reset count", 32'(count[0]), 32'd15);
      chk("reset busy", 32'(busy[0]), 32'd0);
      chk("reset done", 32'(done[0]), 32'd0);
      chk("reset tick", 32'(tick[0]), 32'd0);
      step(20);
      chk("idle count stable", 32'(count[3]), 32'd15);

      // Basic run, P=10, load 3, with an ignored start mid-run.
      go(0, 4'd3);
      chk("basic count after start", 32'(count[0]), 32'd3);
      chk("basic busy after start", 32'(busy[0]), 32'd1);
      step(4);
      load_val[0] = 4'd9;
      start[0]    = 1'b1;
      step(1);
      start[0]    = 1'b0;
      load_val[0] = 4'd3;
      step(5);
      chk("basic first tick count", 32'(count[0]), 32'd2);
      chk("basic first tick", 32'(tick[0]), 32'd1);
      step(19);
      chk("basic pre-done count", 32'(count[0]), 32'd1);
      chk("basic pre-done done", 32'(done[0]), 32'd0);
      step(1);
      chk("basic done count", 32'(count[0]), 32'd0);
      chk("basic done pulse", 32'(done[0]), 32'd1);
      chk("basic busy fall", 32'(busy[0]), 32'd0);
      step(1);
      chk("basic done one cycle", 32'(done[0]), 32'd0);

      // Pause for 7 cycles after the second tick, P=4, load 5.
      go(1, 4'd5);
      step(8);
      chk("pause second tick count", 32'(count[1]), 32'd3);
      pause[1] = 1'b1;
      step(4);
      chk("pause frozen count", 32'(count[1]), 32'd3);
      chk("pause no tick", 32'(tick[1]), 32'd0);
      chk("pause busy", 32'(busy[1]), 32'd1);
      step(3);
      pause[1] = 1'b0;
      step(11);
      chk("pause pre-done count", 32'(count[1]), 32'd1);
      step(1);
      chk("pause late done", 32'(done[1]), 32'd1);
      chk("pause late done count", 32'(count[1]), 32'd0);

      // Abort at count 2, then start+abort collision in IDLE.
      go(1, 4'd5);
      step(13);
      chk("abort pre count", 32'(count[1]), 32'd2);
      abort[1] = 1'b1;
      step(1);
      abort[1] = 1'b0;
      chk("abort count holds", 32'(count[1]), 32'd2);
      chk("abort busy", 32'(busy[1]), 32'd0);
      chk("abort no done", 32'(done[1]), 32'd0);
      step(10);
      chk("abort count later", 32'(count[1]), 32'd2);
      load_val[1] = 4'd7;
      start[1]    = 1'b1;
      abort[1]    = 1'b1;
      step(1);
      start[1]    = 1'b0;
      abort[1]    = 1'b0;
      chk("start+abort busy", 32'(busy[1]), 32'd0);
      chk("start+abort count", 32'(count[1]), 32'd2);
      step(3);

      // Zero load, then P=1 run.
      go(2, 4'd0);
      chk("zero load count", 32'(count[2]), 32'd0);
      chk("zero load done", 32'(done[2]), 32'd1);
      chk("zero load busy", 32'(busy[2]), 32'd0);
      step(1);
      chk("zero load done once", 32'(done[2]), 32'd0);
      go(2, 4'd4);
      chk("p1 count 4", 32'(count[2]), 32'd4);
      step(1);
      chk("p1 count 3", 32'(count[2]), 32'd3);
      chk("p1 tick", 32'(tick[2]), 32'd1);
      step(2);
      chk("p1 count 1", 32'(count[2]), 32'd1);
      step(1);
      chk("p1 count 0", 32'(count[2]), 32'd0);
      chk("p1 done", 32'(done[2]), 32'd1);
      chk("p1 busy fall", 32'(busy[2]), 32'd0);

      // Auto-reload, P=2, load 2, then reset mid-sequence.
      go(3, 4'd2);
      chk("ar count 2", 32'(count[3]), 32'd2);
      step(2);
      chk("ar count 1", 32'(count[3]), 32'd1);
      step(2);
      chk("ar count 0", 32'(count[3]), 32'd0);
      chk("ar done", 32'(done[3]), 32'd1);
      chk("ar busy stays", 32'(busy[3]), 32'd1);
      step(2);
      chk("ar reload count", 32'(count[3]), 32'd2);
      chk("ar reload tick", 32'(tick[3]), 32'd1);
      chk("ar reload no done", 32'(done[3]), 32'd0);
      step(4);
      chk("ar second done", 32'(done[3]), 32'd1);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("ar rst count", 32'(count[3]), 32'd15);
      chk("ar rst busy", 32'(busy[3]), 32'd0);
      chk("ar rst tick", 32'(tick[3]), 32'd0);

      // Auto-reload with a zero value at reload.
      go(3, 4'd1);
      step(2);
      chk("ar1 done", 32'(done[3]), 32'd1);
      load_val[3] = 4'd0;
      step(2);
      chk("ar zero reload count", 32'(count[3]), 32'd0);
      chk("ar zero reload done", 32'(done[3]), 32'd1);
      chk("ar zero reload tick", 32'(tick[3]), 32'd1);
      abort[3] = 1'b1;
      step(1);
      abort[3] = 1'b0;
      chk("ar abort busy", 32'(busy[3]), 32'd0);
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
